// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Build option: MEM_STAGE_SUBWORD_EN enables byte/half accesses and the
// read-modify-write states; without it the stage handles words only.
package mem_stage_pkg;

`ifdef MEM_STAGE_SUBWORD_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_RD = 2'd2,
    RMW_WR = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1
  } state_e;
`endif

  // Access size codes carried on in_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Lane logic assumes a 32-bit data path.
  localparam int unsigned WORD_W = 32;

  // Clears the two byte-offset bits; sliced to the address width at use.
  localparam logic [63:0] WORD_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

  // Natural-alignment rule: bytes never fault, halves need addr[0] = 0,
  // anything else is treated as a word and needs addr[1:0] = 0.
  function automatic logic addr_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Combinational lane handling for the memory stage: merges a sub-word store
// into the old memory word, extracts and extends a sub-word load, and flags
// misaligned accesses. Lanes are little-endian (addr[1:0] = 0 is bits 7:0).
// Build option: MEM_STAGE_SUBWORD_EN; without it this is a word pass-through
// and only a non-zero addr[1:0] is reported as misaligned.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] read_word,
  output logic [WORD_W-1:0] merged_word,
  output logic [WORD_W-1:0] load_value,
  output logic              misaligned
);

`ifdef MEM_STAGE_SUBWORD_EN
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Bit offsets of the addressed byte lane and half lane.
  assign byte_sh   = {addr_lo, 3'b000};
  assign half_sh   = {addr_lo[1], 4'b0000};
  assign byte_lane = read_word[byte_sh +: 8];
  assign half_lane = read_word[half_sh +: 16];

  // Store merge: replace only the addressed lane of the old word.
  always_comb begin
    merged_word = old_word;
    case (size)
      SZ_BYTE: merged_word[byte_sh +: 8]  = store_data[7:0];
      SZ_HALF: merged_word[half_sh +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

  // Load extract: lane shifted to bit 0, then sign- or zero-extended.
  always_comb begin
    case (size)
      SZ_BYTE: load_value = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      SZ_HALF: load_value = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      default: load_value = read_word;
    endcase
  end

  assign misaligned = addr_misaligned(size, addr_lo);
`else
  // Word-only build: size, extension and merge inputs have no effect.
  logic unused_subword;
  assign unused_subword = ^{size, is_unsigned, old_word};

  assign merged_word = store_data;
  assign load_value  = read_word;
  assign misaligned  = (addr_lo != 2'b00);
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage in front of D_MEM. Registers one load, store
// or pass-through per handshake, drives the D_MEM strobes for exactly the
// cycles needed (read-modify-write for sub-word stores) and emits a one-cycle
// result pulse toward MEM/WB.
// Build option: MEM_STAGE_SUBWORD_EN adds byte/half accesses and RMW states.
//
// Handshake: an operation transfers on the rising edge where
// in_valid && in_ready; in_ready is high exactly when the stage is IDLE, so
// a new transfer can coincide with the out_valid pulse of the previous op.
// MEM/WB has no back-pressure: out_valid is a single-cycle pulse.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32  // lane logic supports 32 only
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_err,
  output state_e            dbg_state
);

  state_e            state_q;
  state_e            state_d;
  logic              accept;
  logic              in_is_load;
  logic              in_is_store;
  logic              finish;

  // Registered operation.
  logic              op_load_q;
  logic              op_store_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [4:0]        rd_q;

  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] wdata_hold_q;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] load_value;
  logic              lane_mis;
  logic              op_mis;
  logic [DATA_W-1:0] result;

  assign accept      = in_valid && in_ready;
  // Load and store together is illegal and falls through as pass-through.
  assign in_is_load  = in_load && !in_store;
  assign in_is_store = in_store && !in_load;

  assign in_ready  = (state_q == IDLE);
  assign dbg_state = state_q;
  assign mem_addr  = addr_q & WORD_ALIGN_MASK[ADDR_W-1:0];

`ifdef MEM_STAGE_SUBWORD_EN
  logic rmw_start;
  // Only aligned sub-word stores need the old word; misaligned ones fault.
  assign rmw_start = in_is_store && (in_size == SZ_BYTE || in_size == SZ_HALF)
                     && !addr_misaligned(in_size, in_addr[1:0]);
`else
  logic unused_cfg;
  assign unused_cfg = ^{in_size, in_unsigned};
  assign size_q     = SZ_WORD;
  assign uns_q      = 1'b0;
  assign old_word   = '0;
`endif

  mem_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .store_data  (wdata_q),
    .old_word    (old_word),
    .read_word   (mem_rdata),
    .merged_word (merged_word),
    .load_value  (load_value),
    .misaligned  (lane_mis)
  );

  // Misalignment only matters for real memory accesses.
  assign op_mis = (op_load_q || op_store_q) && lane_mis;

  // Result word presented to MEM/WB when the operation completes.
  always_comb begin
    result = '0;
    if (!op_mis) begin
      if (op_load_q)       result = load_value;
      else if (!op_store_q) result = DATA_W'(addr_q);
    end
  end

  // Next state, D_MEM strobes and write data; wdata holds when idle.
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = wdata_hold_q;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef MEM_STAGE_SUBWORD_EN
          state_d = rmw_start ? RMW_RD : ACCESS;
`else
          state_d = ACCESS;
`endif
        end
      end
      ACCESS: begin
        state_d = IDLE;
        finish  = 1'b1;
        if (!op_mis) begin
          if (op_load_q) begin
            mem_read = 1'b1;
          end else if (op_store_q) begin
            mem_write = 1'b1;
            mem_wdata = wdata_q;
          end
        end
      end
`ifdef MEM_STAGE_SUBWORD_EN
      RMW_RD: begin
        state_d  = RMW_WR;
        mem_read = 1'b1;
      end
      RMW_WR: begin
        state_d   = IDLE;
        finish    = 1'b1;
        mem_write = 1'b1;
        mem_wdata = merged_word;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the accepted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_load_q  <= 1'b0;
      op_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
`ifdef MEM_STAGE_SUBWORD_EN
      size_q     <= SZ_WORD;
      uns_q      <= 1'b0;
`endif
    end else if (accept) begin
      op_load_q  <= in_is_load;
      op_store_q <= in_is_store;
      addr_q     <= in_addr;
      wdata_q    <= in_wdata;
      rd_q       <= in_rd;
`ifdef MEM_STAGE_SUBWORD_EN
      size_q     <= in_size;
      uns_q      <= in_unsigned;
`endif
    end
  end

`ifdef MEM_STAGE_SUBWORD_EN
  // Merge register: old memory word read during RMW_RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 old_word <= '0;
    else if (state_q == RMW_RD) old_word <= mem_rdata;
  end
`endif

  // Remember the last written data so mem_wdata holds between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wdata_hold_q <= '0;
    else if (mem_write) wdata_hold_q <= mem_wdata;
  end

  // Result register: pulse valid, update data/tag/error only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= finish;
      if (finish) begin
        out_data <= result;
        out_rd   <= rd_q;
        out_err  <= op_mis;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a transaction-level reference model
// and a small D_MEM model answering reads combinationally.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_load, in_store, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, mem_addr, mem_wdata, mem_rdata, out_data;
  logic [4:0]  in_rd, out_rd;
  logic        mem_read, mem_write, out_valid, out_err;
  state_e      dbg_state;

  logic [31:0] dmem    [0:63];  // D_MEM contents as written by the DUT
  logic [31:0] ref_mem [0:63];  // reference memory image

  int          cyc, n_checks, n_pass;
  int          plan_rd_cyc, plan_wr_cyc, plan_idx, busy_start, busy_until;
  logic [31:0] plan_addr, plan_wdata, last_wdata, last_out_data;
  logic [4:0]  last_out_rd;

  // Scoreboard: one entry per expected out_valid pulse.
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [4:0]  exp_rd_q[$];
  logic        exp_err_q[$];

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_err(out_err), .dbg_state(dbg_state)
  );

  assign mem_rdata = mem_read ? dmem[mem_addr[7:2]] : 32'h0;

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    logic exp_ov;
    if (!rst_n) begin
      check_b("rst_in_ready", in_ready, 1'b1);
      check_b("rst_mem_read", mem_read, 1'b0);
      check_b("rst_mem_write", mem_write, 1'b0);
      check_b("rst_out_valid", out_valid, 1'b0);
      check_b("rst_out_err", out_err, 1'b0);
      check_w("rst_mem_addr", mem_addr, 32'h0);
      check_w("rst_mem_wdata", mem_wdata, 32'h0);
      check_w("rst_out_data", out_data, 32'h0);
      check_w("rst_out_rd", 32'(out_rd), 32'h0);
      check_b("rst_state_idle", dbg_state == IDLE, 1'b1);
      plan_rd_cyc = -1; plan_wr_cyc = -1; busy_start = 0; busy_until = 0;
      exp_q.delete(); exp_cyc_q.delete(); exp_rd_q.delete(); exp_err_q.delete();
      last_wdata = 32'h0; last_out_data = 32'h0; last_out_rd = 5'h0;
      return;
    end
    check_b("in_ready", in_ready, !(cyc >= busy_start && cyc < busy_until));
    check_b("mem_read", mem_read, cyc == plan_rd_cyc);
    check_b("mem_write", mem_write, cyc == plan_wr_cyc);
    check_b("strobe_excl", mem_read && mem_write, 1'b0);
    if (cyc == plan_rd_cyc || cyc == plan_wr_cyc) check_w("mem_addr", mem_addr, plan_addr);
    if (cyc == plan_wr_cyc) begin
      check_w("mem_wdata", mem_wdata, plan_wdata);
      ref_mem[plan_idx] = plan_wdata;
      last_wdata = plan_wdata;
    end else begin
      check_w("mem_wdata_hold", mem_wdata, last_wdata);
    end
    if (mem_write) dmem[mem_addr[7:2]] = mem_wdata;
    exp_ov = (exp_cyc_q.size() != 0) && (exp_cyc_q[0] == cyc);
    check_b("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      last_out_data = exp_q.pop_front();
      last_out_rd   = exp_rd_q.pop_front();
      void'(exp_cyc_q.pop_front());
      check_w("out_data", out_data, last_out_data);
      check_w("out_rd", 32'(out_rd), 32'(last_out_rd));
      check_b("out_err", out_err, exp_err_q.pop_front());
    end else begin
      check_w("out_data_hold", out_data, last_out_data);
      check_w("out_rd_hold", 32'(out_rd), 32'(last_out_rd));
    end
  endtask

  // One clock cycle: compare on the falling edge, resume 1 ns past rising.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Driver: offer one operation and record what the model says must happen.
  task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic un, input logic [31:0] ad,
                          input logic [31:0] wd, input logic [4:0] rd);
    logic        is_ld, is_st, mis, sx;
    logic [1:0]  esz;
    logic [31:0] word, val, lane_mask;
    int          nbytes, sh, a;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    check_b("ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz;
    in_unsigned = un; in_addr = ad; in_wdata = wd; in_rd = rd;

    is_ld = ld && !st;
    is_st = st && !ld;
`ifdef MEM_STAGE_SUBWORD_EN
    esz = sz;
`else
    esz = SZ_WORD;
    sx  = un;
`endif
    nbytes = (esz == SZ_BYTE) ? 1 : (esz == SZ_HALF) ? 2 : 4;
    mis = (is_ld || is_st) && ((nbytes == 2 && ad[0]) || (nbytes == 4 && ad[1:0] != 2'b00));
    lane_mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    sh   = 8 * int'(ad[1:0]);
    plan_idx  = int'(ad[7:2]);
    word      = ref_mem[plan_idx];
    plan_addr = {ad[31:2], 2'b00};
    a = cyc + 1;
    busy_start = a;
    busy_until = a + 1;
    val = 32'h0;
    if (mis) begin
      val = 32'h0;
    end else if (is_ld) begin
      plan_rd_cyc = a;
      val = (word >> sh) & lane_mask;
      sx  = !un && (nbytes < 4) && val[8 * nbytes - 1];
      if (sx) val = val | ~lane_mask;
    end else if (is_st) begin
      if (nbytes == 4) begin
        plan_wr_cyc = a;
        plan_wdata  = wd;
      end else begin
        plan_rd_cyc = a;
        plan_wr_cyc = a + 1;
        plan_wdata  = (word & ~(lane_mask << sh)) | ((wd & lane_mask) << sh);
        busy_until  = a + 2;
      end
    end else begin
      val = ad;
    end
    exp_q.push_back(val);
    exp_cyc_q.push_back(busy_until);
    exp_rd_q.push_back(rd);
    exp_err_q.push_back(mis);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10 && exp_cyc_q.size() != 0; i++) step();
    check_w("idle_timeout", exp_cyc_q.size(), 0);
  endtask

  initial begin
    logic        ld, st, un;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          k;
    cyc = 0; n_checks = 0; n_pass = 0;
    plan_rd_cyc = -1; plan_wr_cyc = -1; plan_idx = 0; busy_start = 0; busy_until = 0;
    plan_addr = 0; plan_wdata = 0; last_wdata = 0; last_out_data = 0; last_out_rd = 0;
    in_valid = 0; in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Word store then word load of the same location.
    drive_op(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h4, 32'hFFFF_FFFB, 5'd3);
    wait_idle();
    check_w("lit_store_ref", ref_mem[1], 32'hFFFF_FFFB);
    check_w("lit_store_wdata", mem_wdata, 32'hFFFF_FFFB);
    drive_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 5'd7);
    wait_idle();
    check_w("lit_load_data", out_data, 32'hFFFF_FFFB);
    check_w("lit_load_rd", 32'(out_rd), 32'd7);

`ifdef MEM_STAGE_SUBWORD_EN
    // Byte store via RMW, then signed and unsigned byte loads.
    dmem[2] = 32'h1122_3344; ref_mem[2] = 32'h1122_3344;
    drive_op(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h0000_00AB, 5'd1);
    wait_idle();
    check_w("lit_rmw_wdata", mem_wdata, 32'h1122_AB44);
    check_w("lit_rmw_mem", dmem[2], 32'h1122_AB44);
    drive_op(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 5'd2);
    wait_idle();
    check_w("lit_lb_signed", out_data, 32'hFFFF_FFAB);
    drive_op(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, 5'd2);
    wait_idle();
    check_w("lit_lb_unsigned", out_data, 32'h0000_00AB);
    drive_op(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, 5'd9);
    wait_idle();
    check_w("lit_mis_half", out_data, 32'h0);
    check_b("lit_mis_err", out_err, 1'b1);

    // Reset while the RMW read is on the bus: the write must never happen.
    dmem[3] = 32'h1122_3344; ref_mem[3] = 32'h1122_3344;
    drive_op(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'hD, 32'h0000_0055, 5'd4);
    check_b("rmw_rd_seen", mem_read, 1'b1);
    #1 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check_b("ready_after_rst", in_ready, 1'b1);
    step(); step();
    check_w("rmw_abandoned", dmem[3], 32'h1122_3344);
`else
    drive_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h3, 32'h0, 5'd9);
    wait_idle();
    check_w("lit_mis_word", out_data, 32'h0);
    check_b("lit_mis_err", out_err, 1'b1);
`endif

    // Randomized mix, including back-to-back offers and illegal load+store.
    repeat (300) begin
      k  = int'($urandom_range(0, 3));
      ld = (k == 0 || k == 3);
      st = (k == 1 || k == 3);
      sz = 2'($urandom_range(0, 2));
      un = 1'($urandom_range(0, 1));
      ad = (ld || st) ? 32'($urandom_range(0, 255)) : $urandom;
      if ($urandom_range(0, 1) == 1 && (ld || st)) ad[1:0] = 2'b00;
      drive_op(ld, st, sz, un, ad, $urandom, 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
